// File: rtl/miriscv_lsu.sv
// Load-store unit: turns a core load/store into one byte-enabled memory beat and
// extends the read data. Optional misalignment trap via MIRISCV_LSU_MISALIGN_EN.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic        is_byte, is_half, misaligned, issue, done;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, data_q, load_ext;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_byte = (lsu_size_i == 3'd0) || (lsu_size_i == 3'd4);
  assign is_half = (lsu_size_i == 3'd1) || (lsu_size_i == 3'd5);

`ifdef MIRISCV_LSU_MISALIGN_EN
  assign misaligned = (state == IDLE) && lsu_req_i &&
                      ((is_half && lsu_addr_i[0]) ||
                       (!is_byte && !is_half && (lsu_addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign issue = (state == IDLE) && lsu_req_i && !misaligned;
  assign done  = (state == WAIT) && data_rvalid_i;

  always_comb begin
    if (is_byte) begin
      be_new    = 4'b0001 << lsu_addr_i[1:0];
      wdata_new = {4{lsu_data_i[7:0]}};
    end else if (is_half) begin
      be_new    = 4'b0011 << {lsu_addr_i[1], 1'b0};
      wdata_new = {2{lsu_data_i[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = lsu_data_i;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = data_gnt_i ? WAIT : REQ;
      REQ:     if (data_gnt_i) state_next = WAIT;
      WAIT:    if (data_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request outputs: live core fields on the issue cycle, captured copy while waiting for grant
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_addr_o  = 32'h0;
    data_wdata_o = 32'h0;
    case (state)
      IDLE: if (issue) begin
        data_req_o   = 1'b1;
        data_we_o    = lsu_we_i;
        data_be_o    = be_new;
        data_addr_o  = lsu_addr_i;
        data_wdata_o = wdata_new;
      end
      REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = be_q;
        data_addr_o  = addr_q;
        data_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
    end else if (issue) begin
      we_q    <= lsu_we_i;
      be_q    <= be_new;
      addr_q  <= lsu_addr_i;
      wdata_q <= wdata_new;
      size_q  <= lsu_size_i;
      off_q   <= lsu_addr_i[1:0];
    end
  end

  assign byte_sel = data_rdata_i[{off_q, 3'b000} +: 8];
  assign half_sel = data_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_ext = {24'h0, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_ext = {16'h0, half_sel};
      default: load_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          data_q <= 32'h0;
    else if (done && !we_q) data_q <= load_ext;
  end

  assign lsu_data_o      = done ? load_ext : data_q;
  assign lsu_stall_req_o = lsu_req_i && !done && !misaligned;
  assign lsu_misalign_o  = misaligned;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: byte-array reference model, behavioural RAM with
// programmable grant delay, separate request and completion monitors.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        stall, misalign;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_gnt, data_rvalid;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_size_i     (lsu_size),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_wdata),
    .lsu_data_o     (lsu_rdata),
    .lsu_stall_req_o(stall),
    .lsu_misalign_o (misalign),
    .data_req_o     (data_req),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_gnt_i     (data_gnt),
    .data_rvalid_i  (data_rvalid),
    .data_rdata_i   (data_rdata)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic        mis;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] ram [64];

  int   gnt_delay = 0;
  int   cnt = 0;
  logic late_rv = 1'b0;

  assign data_gnt = (cnt >= gnt_delay);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [7:0] base_of(input logic [31:0] a, input int n);
    if (n == 1)      return a[7:0];
    else if (n == 2) return a[7:0] & 8'hFE;
    else             return a[7:0] & 8'hFC;
  endfunction

  // Memory: grant after gnt_delay request cycles, response one cycle after grant
  initial begin
    logic        acc, pend, a_we;
    logic [31:0] a_addr, a_wd;
    logic [3:0]  a_be;
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc    = rst_n && data_req && data_gnt;
      pend   = rst_n && data_req && !data_gnt;
      a_we   = data_we;
      a_addr = data_addr;
      a_be   = data_be;
      a_wd   = data_wdata;
      @(posedge clk);
      #1;
      data_rvalid = 1'b0;
      if (pend) cnt++;
      if (acc) begin
        cnt = 0;
        if (a_we) begin
          for (int j = 0; j < 4; j++)
            if (a_be[j]) ram[a_addr[7:2]][8*j +: 8] = a_wd[8*j +: 8];
        end else begin
          data_rdata = ram[a_addr[7:2]];
        end
        data_rvalid = 1'b1;
      end else if (late_rv) begin
        data_rvalid = 1'b1;
        data_rdata  = 32'hFFFF_FFFF;
        late_rv     = 1'b0;
      end
    end
  end

  // Request monitor
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (rst_n && data_req) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
        end else begin
          e = req_q[0];
          chk("req_we", {31'h0, data_we}, {31'h0, e.we});
          chk("req_be", {28'h0, data_be}, {28'h0, e.be});
          chk("req_addr", data_addr, e.addr);
          if (e.we) chk("req_wdata", data_wdata, e.wdata);
          if (data_gnt) void'(req_q.pop_front());
        end
      end
    end
  end

  // Completion monitor
  initial begin
    int   stall_cnt = 0;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
      end else if (stall) begin
        stall_cnt++;
      end else if (lsu_req) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          if (!e.we && !e.mis) chk("rsp_data", lsu_rdata, e.data);
          chk("rsp_stall", stall_cnt, e.stall);
          chk("rsp_misalign", {31'h0, misalign}, {31'h0, e.mis});
          $display("txn we=%0b size=%0d addr=%h data=%h stall=%0d mis=%0b",
                   e.we, e.size, e.addr, lsu_rdata, stall_cnt, misalign);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] d, input int delay, input logic mis);
    int          n;
    logic [7:0]  base, idx;
    logic [31:0] val, wexp;
    logic [3:0]  be;
    req_t        rq;
    rsp_t        rs;
    n    = nbytes(sz);
    base = base_of(addr, n);
    val  = 32'h0;
    be   = 4'h0;
    for (int i = 0; i < n; i++) begin
      idx = base + 8'(i);
      be[idx[1:0]] = 1'b1;
      if (we && !mis) model_mem[idx] = d[8*i +: 8];
      val[8*i +: 8] = model_mem[idx];
    end
    if (sz == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
    if (sz == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
    for (int j = 0; j < 4; j++) wexp[8*j +: 8] = d[8*(j % n) +: 8];
    if (!mis) begin
      rq.we = we; rq.be = be; rq.addr = addr; rq.wdata = wexp;
      req_q.push_back(rq);
    end
    rs.we = we; rs.size = sz; rs.addr = addr; rs.data = val;
    rs.stall = mis ? 0 : delay + 1; rs.mis = mis;
    rsp_q.push_back(rs);
    gnt_delay = delay;
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = sz;
    lsu_addr  = addr;
    lsu_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 40);
    if (stall) begin
      $display("FAIL txn_timeout: stall still %0b after %0d cycles, required 0", stall, n);
      $fatal(1, "transaction timeout");
    end
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] w, a;
    logic [2:0]  sz;
    logic        we;
    logic [2:0]  ld_sizes [8];
    ld_sizes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int j = 0; j < 4; j++) model_mem[4*i + j] = w[8*j +: 8];
    end

    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, data_req}, 32'h0);
    chk("rst_we", {31'h0, data_we}, 32'h0);
    chk("rst_be", {28'h0, data_be}, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_data", lsu_rdata, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    do_txn(1'b1, 3'd2, 32'h10, 32'h80FF_7F01, 0, 1'b0);
    do_txn(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0);
    do_txn(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0);
    do_txn(1'b1, 3'd1, 32'h22, 32'h0000_ABCD, 0, 1'b0);
    do_txn(1'b0, 3'd5, 32'h22, 32'h0, 0, 1'b0);
    do_txn(1'b0, 3'd1, 32'h22, 32'h0, 0, 1'b0);
    do_txn(1'b0, 3'd2, 32'h10, 32'h0, 3, 1'b0);
`ifdef MIRISCV_LSU_MISALIGN_EN
    do_txn(1'b0, 3'd2, 32'h21, 32'h0, 0, 1'b1);
`else
    do_txn(1'b0, 3'd2, 32'h21, 32'h0, 0, 1'b0);
`endif

    // Reset while waiting for the response; a stray rvalid afterwards must be ignored
    begin
      req_t rq;
      rq.we = 1'b0; rq.be = 4'hF; rq.addr = 32'h40; rq.wdata = 32'h0;
      req_q.push_back(rq);
      gnt_delay = 0;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h40;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      lsu_req = 1'b0;
      #1;
      chk("rstw_req", {31'h0, data_req}, 32'h0);
      chk("rstw_be", {28'h0, data_be}, 32'h0);
      chk("rstw_addr", data_addr, 32'h0);
      chk("rstw_data", lsu_rdata, 32'h0);
      chk("rstw_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      late_rv = 1'b1;
      @(negedge clk);
      chk("late_rv_data", lsu_rdata, 32'h0);
      chk("late_rv_req", {31'h0, data_req}, 32'h0);
      @(posedge clk);
      #1;
      chk("late_rv_dataq", lsu_rdata, 32'h0);
    end

    for (int t = 0; t < 150; t++) begin
      we = ($urandom_range(0, 2) == 0);
      sz = we ? 3'($urandom_range(0, 2)) : ld_sizes[$urandom_range(0, 7)];
      a  = $urandom;
      if (nbytes(sz) == 2) a[0] = 1'b0;
      if (nbytes(sz) == 4) a[1:0] = 2'b00;
      do_txn(we, sz, a, $urandom, $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
